// File: rtl/tetris_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tetris_pkg                                                            |
// | Board geometry, colour/offset widths, drawer states, offset unpacking.|
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package tetris_pkg;

  localparam logic [4:0] BOARD_COLS = 5'd10;
  localparam logic [4:0] BOARD_ROWS = 5'd20;
  localparam int COLOUR_W = 6;
  localparam int OFFSET_W = 2;
  localparam logic [COLOUR_W-1:0] BG_COLOUR = 6'b000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Cell idx occupies bits [2*idx+1 : 2*idx] of the packed offset byte.
  function automatic logic [OFFSET_W-1:0] cell_offset(input logic [7:0] packed_off,
                                                       input logic [1:0] idx);
    return packed_off[{idx, 1'b0} +: OFFSET_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/piece_draw_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | piece_draw_counter                                                    |
// | Cell / py / px scan counter (px innermost) with last-pixel flag.      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module piece_draw_counter #(
  parameter int CELL_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_en,
  output logic [1:0]           o_cell,
  output logic [CELL_LOG2-1:0] o_px,
  output logic [CELL_LOG2-1:0] o_py,
  output logic                 o_last
);

  localparam logic [CELL_LOG2-1:0] c_one = 1;

  logic [1:0]           r_cell;
  logic [CELL_LOG2-1:0] r_px;
  logic [CELL_LOG2-1:0] r_py;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cell <= 2'd0;
      r_px   <= '0;
      r_py   <= '0;
    end else if (i_en) begin
      r_px <= r_px + c_one;
      if (&r_px) begin
        r_py <= r_py + c_one;
        if (&r_py)
          r_cell <= r_cell + 2'd1;
      end
    end
  end

  assign o_cell = r_cell;
  assign o_px   = r_px;
  assign o_py   = r_py;
  assign o_last = (&r_cell) & (&r_px) & (&r_py);

endmodule
`default_nettype wire

// File: rtl/piece_drawer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | piece_drawer                                                          |
// | Scans a tetromino's four cells onto the framebuffer, one pixel/clock. |
// | Optional: PIECE_DRAWER_CLIP_EN suppresses plots of off-board cells.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module piece_drawer
  import tetris_pkg::*;
#(
  parameter int BOARD_X0  = 60,
  parameter int BOARD_Y0  = 20,
  parameter int CELL_LOG2 = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                erase,
  input  logic [3:0]          col,
  input  logic [4:0]          row,
  input  logic [7:0]          X,
  input  logic [7:0]          Y,
  input  logic [COLOUR_W-1:0] colour,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  state_t r_state, w_state_next;
  logic   w_accept;

  logic [3:0]          r_col;
  logic [4:0]          r_row;
  logic [7:0]          r_x_off;
  logic [7:0]          r_y_off;
  logic [COLOUR_W-1:0] r_colour;

  logic [1:0]           w_cell;
  logic [CELL_LOG2-1:0] w_px, w_py;
  logic                 w_last;

  logic [OFFSET_W-1:0] w_dx, w_dy;
  logic [4:0]          w_c, w_r;
  logic [7:0]          w_pix_x;
  logic [6:0]          w_pix_y;
  logic                w_visible;

  logic [7:0]          r_vga_x;
  logic [6:0]          r_vga_y;
  logic [COLOUR_W-1:0] r_vga_colour;
  logic                r_plot, r_busy, r_done;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: if (start) begin
        w_accept     = 1'b1;
        w_state_next = ST_DRAW;
      end
      ST_DRAW: if (w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col    <= '0;
      r_row    <= '0;
      r_x_off  <= '0;
      r_y_off  <= '0;
      r_colour <= '0;
    end else if (w_accept) begin
      r_col    <= col;
      r_row    <= row;
      r_x_off  <= X;
      r_y_off  <= Y;
      r_colour <= erase ? BG_COLOUR : colour;
    end
  end

  piece_draw_counter #(.CELL_LOG2(CELL_LOG2)) u_counter (
    .clk    (clk),
    .rst    (reset),
    .i_clr  (w_accept),
    .i_en   (r_state == ST_DRAW),
    .o_cell (w_cell),
    .o_px   (w_px),
    .o_py   (w_py),
    .o_last (w_last)
  );

  // Modular 8/7-bit sums equal the wider sums truncated to the port widths.
  assign w_dx    = cell_offset(r_x_off, w_cell);
  assign w_dy    = cell_offset(r_y_off, w_cell);
  assign w_c     = 5'(r_col) + 5'(w_dx);
  assign w_r     = r_row + 5'(w_dy);
  assign w_pix_x = 8'(BOARD_X0) + (8'(w_c) << CELL_LOG2) + 8'(w_px);
  assign w_pix_y = 7'(BOARD_Y0) + (7'(w_r) << CELL_LOG2) + 7'(w_py);

`ifdef PIECE_DRAWER_CLIP_EN
  assign w_visible = (w_c < BOARD_COLS) && (w_r < BOARD_ROWS);
`else
  assign w_visible = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
      r_plot       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_plot <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        ST_DRAW: begin
          r_busy       <= 1'b1;
          r_plot       <= w_visible;
          r_vga_x      <= w_pix_x;
          r_vga_y      <= w_pix_y;
          r_vga_colour <= r_colour;
        end
        ST_DONE: begin
          r_busy <= 1'b1;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;
  assign plot       = r_plot;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
`default_nettype wire
